// File: rtl/mesh_row_channel_if.sv
`default_nettype none
// ============================================================================
// Module   : mesh_row_channel_if
// Purpose  : Bundles the eastbound (cw_*) and westbound (ccw_*) send/ready
//            links between the routers of one mesh row and the row channel.
// Ports    : cw_si/cw_di/cw_ro   router east output  -> channel
//            cw_so/cw_do/cw_ri   channel             -> router west input
//            ccw_si/ccw_di/ccw_ro router west output -> channel
//            ccw_so/ccw_do/ccw_ri channel            -> router east input
//            modport master = router side, modport slave = channel side.
// Revision : 1.0  initial release
// ============================================================================
interface mesh_row_channel_if #(
   parameter int COLS         = 4,
   parameter int PACKET_WIDTH = 64
);
   logic [COLS-1:0]              cw_si;
   logic [COLS*PACKET_WIDTH-1:0] cw_di;
   logic [COLS-1:0]              cw_ro;
   logic [COLS-1:0]              cw_so;
   logic [COLS*PACKET_WIDTH-1:0] cw_do;
   logic [COLS-1:0]              cw_ri;

   logic [COLS-1:0]              ccw_si;
   logic [COLS*PACKET_WIDTH-1:0] ccw_di;
   logic [COLS-1:0]              ccw_ro;
   logic [COLS-1:0]              ccw_so;
   logic [COLS*PACKET_WIDTH-1:0] ccw_do;
   logic [COLS-1:0]              ccw_ri;

   modport master (
      output cw_si, cw_di, cw_ri, ccw_si, ccw_di, ccw_ri,
      input  cw_ro, cw_so, cw_do, ccw_ro, ccw_so, ccw_do
   );

   modport slave (
      input  cw_si, cw_di, cw_ri, ccw_si, ccw_di, ccw_ri,
      output cw_ro, cw_so, cw_do, ccw_ro, ccw_so, ccw_do
   );
endinterface
`default_nettype wire

// File: rtl/mesh_row_channel.sv
`default_nettype none
// ============================================================================
// Module   : mesh_link_fifo
// Purpose  : One DEPTH-entry send/ready link FIFO. Ready is decoded from the
//            registered count only, so downstream ready never reaches the
//            upstream ready combinationally.
// Ports    : clk, reset        clock, synchronous active-high reset
//            send_i/data_i     upstream send and flit
//            ready_o           ready back to upstream (count < DEPTH)
//            send_o/data_o     downstream send (count != 0) and head flit
//            ready_i           downstream ready
// Revision : 1.0  initial release
// ============================================================================
module mesh_link_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             send_i,
   input  wire logic [WIDTH-1:0] data_i,
   output logic                  ready_o,
   output logic                  send_o,
   output logic [WIDTH-1:0]      data_o,
   input  wire logic             ready_i
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   c_FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             push_w;
   logic             pop_w;

   assign ready_o = (count_q < c_FULL);
   assign send_o  = (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign push_w  = send_i & ready_o;
   assign pop_w   = send_o & ready_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_w) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + c_PTR_ONE;
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
         end
         // Simultaneous push and pop leaves the count unchanged.
         case ({push_w, pop_w})
            2'b10:   count_q <= count_q + c_CNT_ONE;
            2'b01:   count_q <= count_q - c_CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// ============================================================================
// Module   : mesh_row_channel
// Purpose  : Link fabric for one mesh row of COLS routers: a FIFO per
//            eastbound and westbound link between neighbours, plus
//            always-ready edge sinks that count flits routed off the mesh.
// Ports    : clk, reset        clock, synchronous active-high reset
//            bus               row link bundle (slave side)
//            east_drop_cnt     saturating count of flits router COLS-1 sent east
//            west_drop_cnt     saturating count of flits router 0 sent west
//            drop_pulse        [0] east drop last edge, [1] west drop last edge
// Revision : 1.0  initial release
// ============================================================================
module mesh_row_channel #(
   parameter int COLS         = 4,
   parameter int PACKET_WIDTH = 64,
   parameter int DEPTH        = 2,
   parameter int CNT_W        = 16
) (
   input  wire logic         clk,
   input  wire logic         reset,
   mesh_row_channel_if.slave bus,
   output logic [CNT_W-1:0]  east_drop_cnt,
   output logic [CNT_W-1:0]  west_drop_cnt,
   output logic [1:0]        drop_pulse
);
   localparam int              W         = PACKET_WIDTH;
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

   logic [COLS-1:0]   cw_ro_w;
   logic [COLS-1:0]   cw_so_w;
   logic [COLS*W-1:0] cw_do_w;
   logic [COLS-1:0]   ccw_ro_w;
   logic [COLS-1:0]   ccw_so_w;
   logic [COLS*W-1:0] ccw_do_w;

   logic [CNT_W-1:0]  east_cnt_q;
   logic [CNT_W-1:0]  west_cnt_q;
   logic [1:0]        drop_pulse_q;
   logic              east_acc_w;
   logic              west_acc_w;
   logic              unused_inputs_w;

   // Edge positions: sinks never back-pressure, and no router feeds the
   // west input of column 0 or the east input of column COLS-1.
   assign cw_ro_w[COLS-1]      = 1'b1;
   assign cw_so_w[0]           = 1'b0;
   assign cw_do_w[0 +: W]      = '0;
   assign ccw_ro_w[0]          = 1'b1;
   assign ccw_so_w[COLS-1]     = 1'b0;
   assign ccw_do_w[(COLS-1)*W +: W] = '0;

   for (genvar c = 0; c < COLS-1; c++) begin : g_link
      // Eastbound link c: router c east output -> router c+1 west input.
      mesh_link_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_cw_fifo (
         .clk     (clk),
         .reset   (reset),
         .send_i  (bus.cw_si[c]),
         .data_i  (bus.cw_di[c*W +: W]),
         .ready_o (cw_ro_w[c]),
         .send_o  (cw_so_w[c+1]),
         .data_o  (cw_do_w[(c+1)*W +: W]),
         .ready_i (bus.cw_ri[c+1])
      );
      // Westbound link c: router c+1 west output -> router c east input.
      mesh_link_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_ccw_fifo (
         .clk     (clk),
         .reset   (reset),
         .send_i  (bus.ccw_si[c+1]),
         .data_i  (bus.ccw_di[(c+1)*W +: W]),
         .ready_o (ccw_ro_w[c+1]),
         .send_o  (ccw_so_w[c]),
         .data_o  (ccw_do_w[c*W +: W]),
         .ready_i (bus.ccw_ri[c])
      );
   end

   assign bus.cw_ro  = cw_ro_w;
   assign bus.cw_so  = cw_so_w;
   assign bus.cw_do  = cw_do_w;
   assign bus.ccw_ro = ccw_ro_w;
   assign bus.ccw_so = ccw_so_w;
   assign bus.ccw_do = ccw_do_w;

   // Edge sinks are always ready, so send alone is the transfer.
   assign east_acc_w = bus.cw_si[COLS-1];
   assign west_acc_w = bus.ccw_si[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         east_cnt_q   <= '0;
         west_cnt_q   <= '0;
         drop_pulse_q <= '0;
      end else begin
         if (east_acc_w && (east_cnt_q != c_CNT_MAX)) begin
            east_cnt_q <= east_cnt_q + c_CNT_ONE;
         end
         if (west_acc_w && (west_cnt_q != c_CNT_MAX)) begin
            west_cnt_q <= west_cnt_q + c_CNT_ONE;
         end
         drop_pulse_q <= {west_acc_w, east_acc_w};
      end
   end

   assign east_drop_cnt = east_cnt_q;
   assign west_drop_cnt = west_cnt_q;
   assign drop_pulse    = drop_pulse_q;

   // Edge flit data and the readies of non-existent neighbours are discarded.
   assign unused_inputs_w = ^{bus.cw_ri[0], bus.ccw_ri[COLS-1],
                              bus.cw_di[(COLS-1)*W +: W], bus.ccw_di[0 +: W]};
endmodule
`default_nettype wire

// File: doc/mesh_row_channel.md
# mesh_row_channel

Parametrised horizontal channel fabric for one mesh row of `COLS` routers. It carries the clockwise (eastbound) and counter-clockwise (westbound) links between adjacent routers, replacing direct router-to-router wiring. Each link direction is decoupled by a `DEPTH`-entry FIFO with a send/ready handshake. Both row edges are terminated by always-ready sinks that count and flag flits routed off the mesh. It sits between the routers of a row and the row-level top, one instance per mesh row.

## Interface
- `COLS`, 4, routers in the row; COLS ≥ 2; there are COLS-1 link positions per direction.
- `PACKET_WIDTH`, 64, flit width in bits.
- `DEPTH`, 2, entries per link FIFO; a power of two ≥ 2.
- `CNT_W`, 16, width of each edge drop counter.

Ports (index c = router column c, column 0 = west edge):
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cw_si`  in  COLS  router c east-output send.
- `cw_di`  in  COLS*PACKET_WIDTH  router c east-output flit; slice c is `[c*PACKET_WIDTH +: PACKET_WIDTH]`.
- `cw_ro`  out  COLS  ready back to router c's east output.
- `cw_so`  out  COLS  send to router c's west input; bit 0 is constant 0.
- `cw_do`  out  COLS*PACKET_WIDTH  flit to router c's west input; slice 0 is constant 0.
- `cw_ri`  in  COLS  router c west-input ready; bit 0 is ignored.
- `ccw_si`, `ccw_di`, `ccw_ro`, `ccw_so`, `ccw_do`, `ccw_ri`: westbound mirror of the above. Router c's west output feeds router c-1's east input. `ccw_so[COLS-1]` and its data slice are constant 0; `ccw_ri[COLS-1]` is ignored.
- `east_drop_cnt`  out  CNT_W  count of flits router COLS-1 sent east.
- `west_drop_cnt`  out  CNT_W  count of flits router 0 sent west.
- `drop_pulse`  out  2  bit0 = east drop this cycle, bit1 = west drop this cycle; registered.

## Operation
- **Transfer rule:** a flit transfers on a rising edge when send and ready are both high in that cycle. Data is sampled only in that cycle.
- **Eastbound links:** link c (0 ≤ c ≤ COLS-2) is a FIFO from router c to router c+1.
  - Push: `cw_si[c] & cw_ro[c]`.
  - Pop: `cw_so[c+1] & cw_ri[c+1]`.
- **Westbound links:** link c is a FIFO from router c+1 to router c, with the same push/pop rules.
- **FIFO handshake outputs:**
  - ready = (count < DEPTH), decoded from registered count only; no combinational path from downstream ready.
  - send = (count ≠ 0); data = head entry, valid whenever send is high.
- **FIFO ordering and storage:**
  - Strict FIFO order; read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
- **Boundary conditions:**
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: ready low, so no push that cycle even if a pop occurs; ready rises the cycle after the pop.
  - Empty: send low, so no pop; data output holds the stale head and is don't-care.
- **Edge sinks:**
  - `cw_ro[COLS-1]` and `ccw_ro[0]` are held at 1 (an edge never back-pressures).
  - Each accepted edge flit increments its counter by 1 and saturates at 2^CNT_W − 1; no wrap.
  - The corresponding `drop_pulse` bit is high for exactly the next cycle.
  - Edge flit data is discarded.
- **Unused inputs:** `cw_ri[0]`, `ccw_ri[COLS-1]`, `cw_di` and `ccw_di` have no effect unless a push occurs.

## Timing
- **Reset (synchronous):**
  - All counts, pointers, drop counters and `drop_pulse` go to 0.
  - After reset: every `cw_so`/`ccw_so` = 0, every data output = 0, every link ready = 1, edge readies = 1.
  - Storage contents are also cleared to 0.
- **Reset mid-operation:** all in-flight flits are discarded and no pop is reported in the reset cycle. A handshake in the reset cycle is not a transfer and no counter increments.
- **Latency:** a flit pushed at edge t is presented at the downstream send/data after edge t, i.e. 1 cycle. There is no same-cycle bypass.
- **Throughput:** 1 flit/cycle per link when downstream ready is held high, with DEPTH ≥ 2.
- **Drop timing:** the counter and `drop_pulse` update on the edge that accepts the flit.
- **Link independence:** links are independent. Simultaneous traffic on all 2·(COLS-1) links plus both edges requires no arbitration.

## Test plan
- **Reset values:** reset for 2 cycles → all `*_so` = 0, all link readies = 1, both drop counts = 0, `drop_pulse` = 0.
- **Single-hop latency and order:** COLS=4, DEPTH=2. Router 0 sends 0xA5 at cycle 5 with `cw_ri[1]` = 1 → `cw_so[1]` = 1 with `cw_do[1]` = 0xA5 in cycle 6 only. Then a back-to-back burst 1,2,3,4 arrives in order, one per cycle.
- **Full / back-pressure:**
  - Hold `ccw_ri[1]` = 0; router 2 sends 3 flits.
  - After 2 accepts, `ccw_ro[2]` = 0 and the third waits.
  - Release ready for 1 cycle → the head pops and `ccw_ro[2]` returns to 1 the next cycle.
  - The third flit is accepted later, with no loss or duplication.
- **Simultaneous push/pop at full:** FIFO full, downstream ready high, upstream send high → the pop occurs and no push occurs that cycle. The push occurs next cycle; count sequence 2,1,2.
- **Edge drops and saturation:**
  - Router 3 sends 3 flits east → `east_drop_cnt` = 3 and `drop_pulse[0]` high for 3 cycles.
  - With CNT_W=4, 20 drops → counter holds at 15.
  - West edge checked the same way.
- **Reset mid-operation:** two flits queued on link 1; assert reset for 1 cycle → `cw_so[2]` = 0 the next cycle. A new flit afterwards arrives alone with 1-cycle latency.
